// File: rtl/ibex_fetch_fifo_tracked.sv
// Instruction-aligning fetch FIFO that counts its own outstanding requests and drops stale responses after a flush.
// Zero-latency bypass on an empty FIFO, registered otherwise; in_ready_o grants a request only when its response is guaranteed a slot.
module ibex_fetch_fifo_tracked #(
   parameter int unsigned NUM_REQS = 2,
   parameter bit          ResetAll = 1'b0,
   localparam int unsigned DEPTH  = NUM_REQS + 1,
   localparam int unsigned CW     = $clog2(DEPTH + 1)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          clear_i,
   input  logic          req_sent_i,
   output logic          in_ready_o,
   input  logic          in_valid_i,
   input  logic [31:0]   in_addr_i,
   input  logic [31:0]   in_rdata_i,
   input  logic          in_err_i,
   output logic          out_valid_o,
   input  logic          out_ready_i,
   output logic [31:0]   out_addr_o,
   output logic [31:0]   out_rdata_o,
   output logic          out_err_o,
   output logic [CW-1:0] occupancy_o,
   output logic [CW-1:0] outstanding_o
);

   logic [DEPTH-1:0] r_valid;
   logic [31:0]      r_rdata [DEPTH];
   logic [DEPTH-1:0] r_err;
   logic [CW-1:0]    r_outstanding;
   logic [CW-1:0]    r_discard;
   logic [31:0]      r_addr;

   logic             w_accept_in;
   logic             w_out_accept;
   logic             w_pop;
   logic [31:0]      w_cur_rdata;
   logic [15:0]      w_next_lo;
   logic             w_cur_err;
   logic             w_next_err;
   logic             w_cur_valid;
   logic             w_unaligned_valid;
   logic             w_aligned_comp;
   logic             w_unaligned_comp;
   logic             w_instr_comp;
   logic [DEPTH-1:0] w_lowest_free;
   logic [DEPTH-1:0] w_push_mask;
   logic [DEPTH-1:0] w_valid_pushed;
   logic [DEPTH-1:0] w_valid_popped;
   logic [DEPTH-1:0] w_entry_en;
   logic [31:0]      w_rdata_d [DEPTH];
   logic [DEPTH-1:0] w_err_d;
   logic [CW-1:0]    w_occ;
   logic [CW:0]      w_live;

   // Responses owed to the pre-flush stream never reach the aligner or the entries.
   assign w_accept_in = in_valid_i & (r_discard == '0) & ~clear_i;

   assign w_cur_rdata       = r_valid[0] ? r_rdata[0] : in_rdata_i;
   assign w_cur_err         = r_valid[0] ? r_err[0]   : in_err_i;
   assign w_next_lo         = r_valid[1] ? r_rdata[1][15:0] : in_rdata_i[15:0];
   assign w_next_err        = r_valid[1] ? r_err[1]   : in_err_i;
   assign w_cur_valid       = r_valid[0] | w_accept_in;
   assign w_unaligned_valid = r_valid[1] | (r_valid[0] & w_accept_in);
   assign w_aligned_comp    = w_cur_rdata[1:0]   != 2'b11;
   assign w_unaligned_comp  = w_cur_rdata[17:16] != 2'b11;
   assign w_instr_comp      = r_addr[1] ? w_unaligned_comp : w_aligned_comp;

   always_comb begin
      out_valid_o = w_cur_valid;
      out_rdata_o = w_cur_rdata;
      out_err_o   = w_cur_err;
      if (r_addr[1]) begin
         out_valid_o = w_unaligned_comp ? w_cur_valid : w_unaligned_valid;
         out_rdata_o = {w_next_lo, w_cur_rdata[31:16]};
         out_err_o   = w_cur_err | (~w_unaligned_comp & w_next_err);
      end
   end

   assign out_addr_o   = r_addr;
   assign w_out_accept = out_valid_o & out_ready_i;
   assign w_pop        = w_out_accept & (r_addr[1] | ~w_aligned_comp);

   assign w_lowest_free  = ~r_valid & {r_valid[DEPTH-2:0], 1'b1};
   assign w_push_mask    = w_lowest_free & {DEPTH{w_accept_in}};
   assign w_valid_pushed = r_valid | w_push_mask;
   assign w_valid_popped = w_pop ? {1'b0, w_valid_pushed[DEPTH-1:1]} : w_valid_pushed;
   assign w_entry_en     = w_pop ? w_valid_popped : w_push_mask;

   always_comb begin
      w_err_d = '0;
      for (int i = 0; i < DEPTH - 1; i++) begin
         w_rdata_d[i] = r_valid[i+1] ? r_rdata[i+1] : in_rdata_i;
         w_err_d[i]   = r_valid[i+1] ? r_err[i+1]   : in_err_i;
      end
      w_rdata_d[DEPTH-1] = in_rdata_i;
      w_err_d[DEPTH-1]   = in_err_i;
   end

   always_comb begin
      w_occ = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_occ = w_occ + CW'(r_valid[i]);
      end
   end

   // Entries plus live (non-discarded) requests must leave one slot spare before granting another.
   assign w_live        = {1'b0, w_occ} + {1'b0, r_outstanding} - {1'b0, r_discard};
   assign in_ready_o    = w_live < (CW+1)'(DEPTH - 1);
   assign occupancy_o   = w_occ;
   assign outstanding_o = r_outstanding;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_valid       <= '0;
         r_outstanding <= '0;
         r_discard     <= '0;
         r_addr        <= '0;
      end else begin
         r_outstanding <= r_outstanding + CW'(req_sent_i) - CW'(in_valid_i);
         if (clear_i) begin
            r_valid   <= '0;
            r_discard <= r_outstanding - CW'(in_valid_i);
            r_addr    <= in_addr_i & 32'hFFFF_FFFE;
         end else begin
            r_valid <= w_valid_popped;
            if (in_valid_i && (r_discard != '0)) begin
               r_discard <= r_discard - CW'(1);
            end
            if (w_out_accept) begin
               r_addr <= r_addr + (w_instr_comp ? 32'd2 : 32'd4);
            end
         end
      end
   end

   if (ResetAll) begin : g_data_rst
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
               r_rdata[i] <= '0;
            end
            r_err <= '0;
         end else begin
            for (int i = 0; i < DEPTH; i++) begin
               if (w_entry_en[i]) begin
                  r_rdata[i] <= w_rdata_d[i];
                  r_err[i]   <= w_err_d[i];
               end
            end
         end
      end
   end else begin : g_data_nrst
      always_ff @(posedge clk_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (w_entry_en[i]) begin
               r_rdata[i] <= w_rdata_d[i];
               r_err[i]   <= w_err_d[i];
            end
         end
      end
   end

   a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(w_accept_in && (&r_valid)));
   a_req_ready: assert property (@(posedge clk_i) disable iff (!rst_ni)
      req_sent_i |-> in_ready_o);
   a_rsp_owed: assert property (@(posedge clk_i) disable iff (!rst_ni)
      in_valid_i |-> (r_outstanding != '0));
   a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(req_sent_i && !in_valid_i && (r_outstanding == '1)));

endmodule

// File: tb/tb_ibex_fetch_fifo_tracked.sv
// Scoreboarded bench for the tracked fetch FIFO plus a back-pressure sweep over NUM_REQS = 1, 2, 4.
module tb_ibex_fetch_fifo_tracked;

   localparam int NR = 2;
   localparam int CW = $clog2(NR + 2);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clear = 1'b0;
   logic          req_sent = 1'b0;
   logic          in_ready;
   logic          in_valid = 1'b0;
   logic [31:0]   in_addr = '0;
   logic [31:0]   in_rdata = '0;
   logic          in_err = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [31:0]   out_addr;
   logic [31:0]   out_rdata;
   logic          out_err;
   logic [CW-1:0] occ;
   logic [CW-1:0] outs;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] rdata;
      logic        comp;
      logic        err;
   } exp_t;
   exp_t sb_q[$];
   exp_t mon_e;

   always #5 clk = ~clk;

   ibex_fetch_fifo_tracked #(.NUM_REQS(NR), .ResetAll(1'b0)) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .req_sent_i(req_sent),
      .in_ready_o(in_ready), .in_valid_i(in_valid), .in_addr_i(in_addr),
      .in_rdata_i(in_rdata), .in_err_i(in_err), .out_valid_o(out_valid),
      .out_ready_i(out_ready), .out_addr_o(out_addr), .out_rdata_o(out_rdata),
      .out_err_o(out_err), .occupancy_o(occ), .outstanding_o(outs)
   );

   // Back-pressure sweep instances
   logic        bp_req [3];
   logic        bp_vld [3];
   logic        bp_sent [3];
   logic        bp_rdy [3];
   logic        bp_ovld [3];
   logic        bp_oerr [3];
   logic [31:0] bp_oaddr [3];
   logic [31:0] bp_odata [3];
   logic [7:0]  bp_occ [3];
   logic [7:0]  bp_outs [3];
   int          bp_max [3];

   for (genvar g = 0; g < 3; g++) begin : g_bp
      localparam int BNR = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
      localparam int BCW = $clog2(BNR + 2);
      logic [BCW-1:0] b_occ;
      logic [BCW-1:0] b_outs;
      ibex_fetch_fifo_tracked #(.NUM_REQS(BNR), .ResetAll(g == 1)) u_bp (
         .clk_i(clk), .rst_ni(rst_n), .clear_i(1'b0), .req_sent_i(bp_req[g]),
         .in_ready_o(bp_rdy[g]), .in_valid_i(bp_vld[g]), .in_addr_i(32'h0),
         .in_rdata_i(32'h0000_0013), .in_err_i(1'b0), .out_valid_o(bp_ovld[g]),
         .out_ready_i(1'b0), .out_addr_o(bp_oaddr[g]), .out_rdata_o(bp_odata[g]),
         .out_err_o(bp_oerr[g]), .occupancy_o(b_occ), .outstanding_o(b_outs)
      );
      assign bp_occ[g]  = 8'(b_occ);
      assign bp_outs[g] = 8'(b_outs);
   end

   task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic exp_push(input logic [31:0] a, input logic [31:0] d, input logic c, input logic e);
      exp_t x;
      x.addr = a; x.rdata = d; x.comp = c; x.err = e;
      sb_q.push_back(x);
   endtask

   // Inputs change on the falling edge; direct checks 1 ns later.
   task automatic step(input logic req, input logic vld, input logic [31:0] d, input logic e);
      @(negedge clk);
      clear = 1'b0; req_sent = req; in_valid = vld; in_rdata = d; in_err = e;
      #1;
   endtask

   task automatic flush(input logic [31:0] a);
      @(negedge clk);
      clear = 1'b1; in_addr = a; req_sent = 1'b0; in_valid = 1'b0; in_err = 1'b0;
      #1;
   endtask

   // Output monitor: every accepted instruction must match the head of the scoreboard.
   always @(negedge clk) begin
      #4;
      if (rst_n && out_valid && out_ready && !clear) begin
         chk_eq("sb_expected", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            chk_eq("sb_addr", out_addr, mon_e.addr);
            chk_eq("sb_rdata", mon_e.comp ? {16'h0, out_rdata[15:0]} : out_rdata,
                   mon_e.comp ? {16'h0, mon_e.rdata[15:0]} : mon_e.rdata);
            chk_eq("sb_err", 32'(out_err), 32'(mon_e.err));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      for (int g = 0; g < 3; g++) begin
         bp_req[g] = 1'b0; bp_vld[g] = 1'b0; bp_sent[g] = 1'b0; bp_max[g] = 0;
      end
      repeat (2) @(negedge clk);
      #1;
      chk_eq("rst_occ", 32'(occ), 0);
      chk_eq("rst_outs", 32'(outs), 0);
      chk_eq("rst_in_ready", 32'(in_ready), 1);
      chk_eq("rst_out_valid", 32'(out_valid), 0);
      chk_eq("rst_addr", out_addr, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Aligned bypass at 0x100
      flush(32'h100);
      step(1'b1, 1'b0, 32'h0, 1'b0);
      exp_push(32'h100, 32'h0000_0013, 1'b0, 1'b0);
      step(1'b0, 1'b1, 32'h0000_0013, 1'b0);
      chk_eq("byp_valid", 32'(out_valid), 1);
      chk_eq("byp_addr", out_addr, 32'h100);
      chk_eq("byp_rdata", out_rdata, 32'h13);
      chk_eq("byp_outs", 32'(outs), 1);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      chk_eq("byp_next_addr", out_addr, 32'h104);
      chk_eq("byp_idle_valid", 32'(out_valid), 0);
      chk_eq("byp_outs_done", 32'(outs), 0);

      // Unaligned split at 0x102
      flush(32'h102);
      step(1'b1, 1'b0, 32'h0, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b1, 32'h0013_ABCD, 1'b0);
      chk_eq("split_wait_valid", 32'(out_valid), 0);
      chk_eq("split_in_ready", 32'(in_ready), 0);
      exp_push(32'h102, 32'h1234_0013, 1'b0, 1'b0);
      exp_push(32'h106, 32'h0000_0000, 1'b1, 1'b0);
      step(1'b0, 1'b1, 32'h0000_1234, 1'b0);
      chk_eq("split_valid", 32'(out_valid), 1);
      chk_eq("split_rdata", out_rdata, 32'h1234_0013);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      chk_eq("split_next_addr", out_addr, 32'h106);
      chk_eq("split_occ", 32'(occ), 1);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      chk_eq("split_final_addr", out_addr, 32'h108);
      chk_eq("split_final_occ", 32'(occ), 0);

      // Compressed pair at 0x200
      flush(32'h200);
      step(1'b1, 1'b0, 32'h0, 1'b0);
      exp_push(32'h200, 32'h0000_4581, 1'b1, 1'b0);
      exp_push(32'h202, 32'h0000_4501, 1'b1, 1'b0);
      step(1'b0, 1'b1, 32'h4501_4581, 1'b0);
      chk_eq("cpair_valid0", 32'(out_valid), 1);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      chk_eq("cpair_addr1", out_addr, 32'h202);
      chk_eq("cpair_occ_nopop", 32'(occ), 1);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      chk_eq("cpair_occ_pop", 32'(occ), 0);
      chk_eq("cpair_addr2", out_addr, 32'h204);

      // Flush with two requests in flight
      flush(32'h300);
      step(1'b1, 1'b0, 32'h0, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b0);
      flush(32'h400);
      chk_eq("fl_outs_at_clear", 32'(outs), 2);
      chk_eq("fl_ready_full", 32'(in_ready), 0);
      step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
      chk_eq("fl_drop1_valid", 32'(out_valid), 0);
      chk_eq("fl_drop1_outs", 32'(outs), 2);
      chk_eq("fl_ready_after", 32'(in_ready), 1);
      step(1'b0, 1'b1, 32'hCAFE_F00D, 1'b0);
      chk_eq("fl_drop2_valid", 32'(out_valid), 0);
      chk_eq("fl_drop2_outs", 32'(outs), 1);
      step(1'b1, 1'b0, 32'h0, 1'b0);
      chk_eq("fl_drained_outs", 32'(outs), 0);
      exp_push(32'h400, 32'h0000_0513, 1'b0, 1'b0);
      step(1'b0, 1'b1, 32'h0000_0513, 1'b0);
      chk_eq("fl_third_valid", 32'(out_valid), 1);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      chk_eq("fl_third_addr", out_addr, 32'h404);

      // Error on upper word of unaligned uncompressed
      flush(32'h502);
      step(1'b1, 1'b0, 32'h0, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b1, 32'h0013_0000, 1'b0);
      exp_push(32'h502, 32'h5678_0013, 1'b0, 1'b1);
      exp_push(32'h506, 32'h0000_0000, 1'b1, 1'b1);
      step(1'b0, 1'b1, 32'h0000_5678, 1'b1);
      chk_eq("err_unc_valid", 32'(out_valid), 1);
      chk_eq("err_unc_err", 32'(out_err), 1);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b0);

      // Same error under an unaligned compressed instruction
      out_ready = 1'b0;
      flush(32'h602);
      step(1'b1, 1'b0, 32'h0, 1'b0);
      step(1'b1, 1'b0, 32'h0, 1'b0);
      step(1'b0, 1'b1, 32'h0001_0000, 1'b0);
      step(1'b0, 1'b1, 32'h0000_0000, 1'b1);
      step(1'b0, 1'b0, 32'h0, 1'b0);
      chk_eq("err_c_occ", 32'(occ), 2);
      chk_eq("err_c_valid", 32'(out_valid), 1);
      chk_eq("err_c_err", 32'(out_err), 0);
      exp_push(32'h602, 32'h0000_0001, 1'b1, 1'b0);
      exp_push(32'h604, 32'h0000_0000, 1'b1, 1'b1);
      exp_push(32'h606, 32'h0000_0000, 1'b1, 1'b1);
      out_ready = 1'b1;
      repeat (4) step(1'b0, 1'b0, 32'h0, 1'b0);
      chk_eq("sb_drained", 32'(sb_q.size()), 0);
      chk_eq("end_occ", 32'(occ), 0);

      // Back-pressure sweep: keep requesting with no pops
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         for (int g = 0; g < 3; g++) begin
            bp_vld[g]  = bp_sent[g];
            bp_req[g]  = (c < 12) ? bp_rdy[g] : 1'b0;
            bp_sent[g] = bp_req[g];
         end
         #1;
         for (int g = 0; g < 3; g++) begin
            if (int'(bp_occ[g]) + int'(bp_outs[g]) > bp_max[g]) begin
               bp_max[g] = int'(bp_occ[g]) + int'(bp_outs[g]);
            end
         end
      end
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
         bp_req[g] = 1'b0; bp_vld[g] = 1'b0;
      end
      #1;
      for (int g = 0; g < 3; g++) begin
         chk_eq($sformatf("bp%0d_max_live", g), 32'(bp_max[g]), 32'((g == 0) ? 1 : ((g == 1) ? 2 : 4)));
         chk_eq($sformatf("bp%0d_occ", g), 32'(bp_occ[g]), 32'((g == 0) ? 1 : ((g == 1) ? 2 : 4)));
         chk_eq($sformatf("bp%0d_outs", g), 32'(bp_outs[g]), 0);
         chk_eq($sformatf("bp%0d_ready", g), 32'(bp_rdy[g]), 0);
         chk_eq($sformatf("bp%0d_head_valid", g), 32'(bp_ovld[g]), 1);
         chk_eq($sformatf("bp%0d_head_addr", g), bp_oaddr[g], 0);
         chk_eq($sformatf("bp%0d_head_rdata", g), bp_odata[g], 32'h13);
         chk_eq($sformatf("bp%0d_head_err", g), 32'(bp_oerr[g]), 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
